// File: rtl/half_adder_bist_if.sv
// Connection bundle between the BIST controller (master) and its tester/half-adder side (slave).
interface half_adder_bist_if;
  localparam int unsigned ERR_W = 3;
  localparam int unsigned VEC_W = 2;

  logic             start;
  logic             dut_a;
  logic             dut_b;
  logic             dut_o;
  logic             dut_c;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             first_fail_vld;
  logic [VEC_W-1:0] first_fail_vec;

  modport master (
    input  start, dut_o, dut_c,
    output dut_a, dut_b, busy, done, pass, err_count, first_fail_vld, first_fail_vec
  );

  modport slave (
    output start, dut_o, dut_c,
    input  dut_a, dut_b, busy, done, pass, err_count, first_fail_vld, first_fail_vec
  );
endinterface

// File: rtl/half_adder_bist.sv
// Exhaustive built-in self test for a half-adder: applies 00,01,10,11, holds each
// for SETTLE cycles, checks sum/carry and reports error count and first failing vector.
module half_adder_bist #(
  parameter int unsigned SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  half_adder_bist_if.master  bus
);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = 3;
  localparam int unsigned VEC_W = 2;
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(4);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(3);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             ffv_q, ffv_d;
  logic [VEC_W-1:0] ffvec_q, ffvec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             mismatch;

  // Either response bit wrong counts as a single failing vector.
  assign mismatch = (bus.dut_o != (vec_q[1] ^ vec_q[0])) ||
                    (bus.dut_c != (vec_q[1] & vec_q[0]));

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          err_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
          vec_d   = '0;
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          err_d = (err_q == ERR_MAX) ? ERR_MAX : err_q + ERR_W'(1);
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = vec_q;
          end
        end
        if (vec_q == VEC_LAST) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + VEC_W'(1);
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_WAIT) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
    pass_d = (state_d == ST_DONE) && (err_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Stimulus comes straight off the vector flops so it cannot glitch.
  assign bus.dut_a          = vec_q[1];
  assign bus.dut_b          = vec_q[0];
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.first_fail_vld = ffv_q;
  assign bus.first_fail_vec = ffvec_q;
endmodule
